bus_arbiter: RTL and testbench

Central arbiter for the serial system bus. Grants the bus to one of N_MASTERS masters with round-robin fairness and sequences split transactions: when a selected slave reports busy, it parks the owning master, frees the bus for others, and re-grants the parked master with a resume pulse once the slave is ready. It sits between master request lines and the shared bus control signals (B_SPLIT, B_SPL_RESUME) consumed by every slave.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the serial system bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Largest master count the arbiter is built for
    localparam int N_MASTERS_MAX = 4;

    // Width of a master index (round-robin pointer, owner, split master)
    localparam int c_PTR_W = $clog2(N_MASTERS_MAX);

    // Arbiter states: bus free, bus granted, one-cycle split resume
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWNED  = 2'd1,
        RESUME = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request searching upward from i_ptr+1 (modulo N), one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       i_req,
    input  logic [c_PTR_W-1:0] i_ptr,
    output logic [N-1:0]       o_gnt,
    output logic               o_valid
);

    // Walk the candidates in priority order; the first hit wins
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_valid && i_req[j] && (j == ((int'(i_ptr) + i) % N))) begin
                    o_gnt[j] = 1'b1;
                    o_valid  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin bus arbiter with single-outstanding split
//               transaction sequencing (park, free the bus, resume).
//               Optional grant timeout enabled by BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] M_BREQ,
    output logic [N_MASTERS-1:0] M_BGRANT,
    output logic [N_MASTERS-1:0] M_SPLIT,
    input  logic                 B_SBSY,
    input  logic                 S_SPL_READY,
    output logic                 B_SPLIT,
    output logic                 B_SPL_RESUME,
    output logic                 B_BUSY,
    output logic                 B_TOUT
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   w_owner_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [c_PTR_W-1:0]   r_split_idx;
    logic [c_PTR_W-1:0]   w_split_idx_nxt;
    logic [c_PTR_W-1:0]   w_pick_idx;
    logic                 r_split_pend;
    logic                 w_split_pend_nxt;
    logic [N_MASTERS-1:0] r_bgrant;
    logic [N_MASTERS-1:0] w_bgrant_nxt;
    logic [N_MASTERS-1:0] w_eligible;
    logic [N_MASTERS-1:0] w_pick_gnt;
    logic [N_MASTERS-1:0] w_split_oh;
    logic                 w_pick_valid;
    logic                 w_owner_req;
    logic                 w_tout_hit;
    logic                 r_tout;
    logic                 w_tout_nxt;

    // Owner's request line and the parked master as a one-hot vector
    always_comb begin
        w_owner_req = 1'b0;
        w_split_oh  = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (int'(r_owner) == j) begin
                w_owner_req = M_BREQ[j];
            end
            if (int'(r_split_idx) == j) begin
                w_split_oh[j] = 1'b1;
            end
        end
    end

    // A parked master never competes for the bus
    assign w_eligible = M_BREQ & ~(r_split_pend ? w_split_oh : '0);

    rr_pick #(
        .N (N_MASTERS)
    ) u_rr_pick (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

    // Index of the master chosen by the round-robin selector
    always_comb begin
        w_pick_idx = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (w_pick_gnt[j]) begin
                w_pick_idx = j[c_PTR_W-1:0];
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    logic [c_CNT_W-1:0] r_cnt;

    // Count consecutive OWNED cycles; any other transition restarts at zero
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if ((r_state == OWNED) && (w_state_nxt == OWNED)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_tout_hit = (r_cnt == c_CNT_W'(TIMEOUT - 1));
`else
    logic w_unused_timeout;

    assign w_tout_hit       = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // Next-state and next-output decision; the grant register follows it
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_ptr_nxt        = r_ptr;
        w_split_pend_nxt = r_split_pend;
        w_split_idx_nxt  = r_split_idx;
        w_bgrant_nxt     = r_bgrant;
        w_tout_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                w_bgrant_nxt = '0;
                // A ready split slave outranks fresh requests
                if (r_split_pend && S_SPL_READY) begin
                    w_state_nxt  = RESUME;
                    w_owner_nxt  = r_split_idx;
                    w_bgrant_nxt = w_split_oh;
                end else if (w_pick_valid) begin
                    w_state_nxt  = OWNED;
                    w_owner_nxt  = w_pick_idx;
                    w_bgrant_nxt = w_pick_gnt;
                end
            end
            OWNED: begin
                if (!w_owner_req) begin
                    w_state_nxt  = IDLE;
                    w_bgrant_nxt = '0;
                    w_ptr_nxt    = r_owner;
                end else if (B_SBSY && !r_split_pend) begin
                    w_state_nxt      = IDLE;
                    w_bgrant_nxt     = '0;
                    w_ptr_nxt        = r_owner;
                    w_split_pend_nxt = 1'b1;
                    w_split_idx_nxt  = r_owner;
                end else if (w_tout_hit) begin
                    w_state_nxt  = IDLE;
                    w_bgrant_nxt = '0;
                    w_ptr_nxt    = r_owner;
                    w_tout_nxt   = 1'b1;
                end
            end
            RESUME: begin
                // Grant stays asserted; the split record retires here
                w_state_nxt      = OWNED;
                w_split_pend_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_bgrant_nxt = '0;
            end
        endcase
    end

    // State, pointer, split record and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_split_pend <= 1'b0;
            r_split_idx  <= '0;
            r_bgrant     <= '0;
            r_tout       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_ptr        <= w_ptr_nxt;
            r_split_pend <= w_split_pend_nxt;
            r_split_idx  <= w_split_idx_nxt;
            r_bgrant     <= w_bgrant_nxt;
            r_tout       <= w_tout_nxt;
        end
    end

    assign M_BGRANT     = r_bgrant;
    assign M_SPLIT      = r_split_pend ? w_split_oh : '0;
    assign B_SPLIT      = r_split_pend;
    assign B_SPL_RESUME = (r_state == RESUME);
    assign B_BUSY       = |r_bgrant;
    assign B_TOUT       = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter (N_MASTERS=2, TIMEOUT=8):
//               directed scenarios followed by randomized traffic, compared
//               against a transaction-level reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N   = 2;
    localparam int TMO = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] M_BREQ = '0;
    logic [N-1:0] M_BGRANT;
    logic [N-1:0] M_SPLIT;
    logic         B_SBSY = 1'b0;
    logic         S_SPL_READY = 1'b0;
    logic         B_SPLIT;
    logic         B_SPL_RESUME;
    logic         B_BUSY;
    logic         B_TOUT;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who holds the bus (-1 none), who is parked (-1 none)
    int m_owner  = -1;
    int m_parked = -1;
    int m_ptr    = 0;
    int m_held   = 0;
    bit m_resume = 1'b0;
    bit m_tout   = 1'b0;

    bus_arbiter #(
        .N_MASTERS (N),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .M_BREQ       (M_BREQ),
        .M_BGRANT     (M_BGRANT),
        .M_SPLIT      (M_SPLIT),
        .B_SBSY       (B_SBSY),
        .S_SPL_READY  (S_SPL_READY),
        .B_SPLIT      (B_SPLIT),
        .B_SPL_RESUME (B_SPL_RESUME),
        .B_BUSY       (B_BUSY),
        .B_TOUT       (B_TOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one bus cycle using the inputs seen at the edge
    task automatic model_step();
        m_tout = 1'b0;
        if (RST) begin
            m_owner  = -1;
            m_parked = -1;
            m_ptr    = 0;
            m_held   = 0;
            m_resume = 1'b0;
        end else if (m_resume) begin
            m_resume = 1'b0;
            m_parked = -1;
            m_held   = 0;
        end else if (m_owner < 0) begin
            if (m_parked >= 0 && S_SPL_READY) begin
                m_resume = 1'b1;
                m_owner  = m_parked;
                m_held   = 0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (m_owner < 0 && M_BREQ[c] && c != m_parked) begin
                        m_owner = c;
                        m_held  = 0;
                    end
                end
            end
        end else begin
            if (!M_BREQ[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else if (B_SBSY && m_parked < 0) begin
                m_parked = m_owner;
                m_ptr    = m_owner;
                m_owner  = -1;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (m_held == TMO - 1) begin
                m_tout  = 1'b1;
                m_ptr   = m_owner;
                m_owner = -1;
            end
`endif
            else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all();
        int eg;
        int es;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        es = (m_parked >= 0 && !(m_resume == 1'b0 && m_owner == m_parked && m_parked < 0)) ? (1 << m_parked) : 0;
        chk("grant",  32'(M_BGRANT),     32'(eg));
        chk("msplit", 32'(M_SPLIT),      32'(es));
        chk("bsplit", 32'(B_SPLIT),      32'(m_parked >= 0));
        chk("resume", 32'(B_SPL_RESUME), 32'(m_resume));
        chk("busy",   32'(B_BUSY),       32'(m_owner >= 0));
        chk("tout",   32'(B_TOUT),       32'(m_tout));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int tcnt;

        // Reset
        RST = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(M_BGRANT), 32'h0);
        chk("rst_bsplit", 32'(B_SPLIT), 32'h0);
        RST = 1'b0;

        // Basic grant and release
        M_BREQ = 2'b01;
        tick();
        chk("basic_grant", 32'(M_BGRANT), 32'h1);
        repeat (4) tick();
        chk("basic_hold", 32'(M_BGRANT), 32'h1);
        M_BREQ = 2'b00;
        tick();
        chk("basic_release", 32'(M_BGRANT), 32'h0);
        chk("basic_busy", 32'(B_BUSY), 32'h0);

        // Round robin with an idle cycle between owners
        M_BREQ = 2'b11;
        tick();
        chk("rr_first", 32'(M_BGRANT), 32'h2);
        repeat (2) tick();
        M_BREQ = 2'b01;
        tick();
        chk("rr_gap", 32'(M_BGRANT), 32'h0);
        M_BREQ = 2'b11;
        tick();
        chk("rr_second", 32'(M_BGRANT), 32'h1);
        repeat (2) tick();
        M_BREQ = 2'b10;
        tick();
        M_BREQ = 2'b11;
        tick();
        chk("rr_third", 32'(M_BGRANT), 32'h2);
        M_BREQ = 2'b00;
        tick();

        // Split by master 0, master 1 served, then resume
        M_BREQ = 2'b01;
        tick();
        chk("split_owner", 32'(M_BGRANT), 32'h1);
        M_BREQ = 2'b11;
        B_SBSY = 1'b1;
        tick();
        chk("split_msplit", 32'(M_SPLIT), 32'h1);
        chk("split_bsplit", 32'(B_SPLIT), 32'h1);
        chk("split_drop", 32'(M_BGRANT), 32'h0);
        B_SBSY = 1'b0;
        tick();
        chk("split_other", 32'(M_BGRANT), 32'h2);
        B_SBSY = 1'b1;
        tick();
        chk("split_ignore_grant", 32'(M_BGRANT), 32'h2);
        chk("split_ignore_msplit", 32'(M_SPLIT), 32'h1);
        B_SBSY = 1'b0;
        M_BREQ = 2'b01;
        S_SPL_READY = 1'b1;
        tick();
        tick();
        chk("resume_strobe", 32'(B_SPL_RESUME), 32'h1);
        chk("resume_grant", 32'(M_BGRANT), 32'h1);
        chk("resume_bsplit", 32'(B_SPLIT), 32'h1);
        S_SPL_READY = 1'b0;
        tick();
        chk("resume_done_bsplit", 32'(B_SPLIT), 32'h0);
        chk("resume_done_msplit", 32'(M_SPLIT), 32'h0);
        chk("resume_done_grant", 32'(M_BGRANT), 32'h1);
        M_BREQ = 2'b00;
        tick();

        // Reset during RESUME
        M_BREQ = 2'b01;
        tick();
        B_SBSY = 1'b1;
        tick();
        B_SBSY = 1'b0;
        M_BREQ = 2'b00;
        S_SPL_READY = 1'b1;
        tick();
        chk("rr_resume_state", 32'(B_SPL_RESUME), 32'h1);
        RST = 1'b1;
        tick();
        chk("rst_mid_grant", 32'(M_BGRANT), 32'h0);
        chk("rst_mid_msplit", 32'(M_SPLIT), 32'h0);
        chk("rst_mid_resume", 32'(B_SPL_RESUME), 32'h0);
        RST = 1'b0;
        S_SPL_READY = 1'b0;
        M_BREQ = 2'b11;
        tick();
        chk("rst_ptr_zero", 32'(M_BGRANT), 32'h2);
        M_BREQ = 2'b00;
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // Grant revoked after TMO cycles, then re-granted after one idle
        tcnt = 0;
        M_BREQ = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= 10 && B_TOUT) tcnt++;
            if (i == 10) chk("tout_regrant", 32'(M_BGRANT), 32'h1);
        end
        chk("tout_once", 32'(tcnt), 32'h1);
        M_BREQ = 2'b00;
        tick();
`else
        tcnt = 0;
        M_BREQ = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (B_TOUT) tcnt++;
        end
        chk("no_tout", 32'(tcnt), 32'h0);
        M_BREQ = 2'b00;
        tick();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            RST = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) M_BREQ[b] = ~M_BREQ[b];
            end
            B_SBSY      = ($urandom_range(0, 7) == 0);
            S_SPL_READY = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
